// File: rtl/conv_frame_writer_pkg.sv
// Shared types and defaults for the convolution frame writer.
package conv_frame_writer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_e;

    localparam int unsigned DEF_W = 220;
    localparam int unsigned DEF_H = 220;

    // A 1x3 kernel loses one border column on each side.
    function automatic int unsigned out_width(input int unsigned w);
        return w - 2;
    endfunction

endpackage

// File: rtl/conv_frame_writer_frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
module conv_frame_writer_frame_ram #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rd_data_q;

    // Write port; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read; a same-cycle write to the same address returns the old word.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/conv_frame_writer.sv
// Stores valid convolution output pixels into a frame buffer, tracks
// row/col position, running pixel sum and dropped beats.
module conv_frame_writer
    import conv_frame_writer_pkg::*;
#(
    parameter int unsigned W      = DEF_W,
    parameter int unsigned H      = DEF_H,
    parameter int unsigned OUT_W  = out_width(W),
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        pxl_in,
    input  logic              valid_in,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       row,
    output logic [15:0]       col,
    output logic [23:0]       pix_sum,
    output logic [15:0]       drop_cnt
);

    state_e            state_q, state_d;
    logic [15:0]       row_q, row_d;
    logic [15:0]       col_q, col_d;
    logic [23:0]       sum_q, sum_d;
    logic [15:0]       drop_q, drop_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;
    logic              we;
    logic              last_col;
    logic              last_pix;

    assign last_col = (col_q == 16'(OUT_W - 1));
    assign last_pix = last_col && (row_q == 16'(H - 1));

    // Next-state, counter and write-enable logic.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        sum_d   = sum_q;
        drop_d  = drop_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        we      = 1'b0;
        case (state_q)
            CAPTURE: begin
                if (valid_in) begin
                    we     = 1'b1;
                    sum_d  = sum_q + {16'd0, pxl_in};
                    addr_d = addr_q + 1'b1;
                    if (last_pix) begin
                        // row/col hold at the final position while DONE
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (last_col) begin
                        col_d = '0;
                        row_d = row_q + 16'd1;
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                end
            end
            IDLE, DONE: begin
                if (valid_in && (drop_q != '1)) begin
                    drop_d = drop_q + 16'd1;
                end
                if (start) begin
                    state_d = CAPTURE;
                    row_d   = '0;
                    col_d   = '0;
                    sum_d   = '0;
                    addr_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            sum_q   <= '0;
            drop_q  <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            sum_q   <= sum_d;
            drop_q  <= drop_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    conv_frame_writer_frame_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (8)
    ) u_frame_ram (
        .clk_i     (clk),
        .reset_i   (reset),
        .we_i      (we),
        .wr_addr_i (addr_q),
        .wr_data_i (pxl_in),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    assign busy       = (state_q == CAPTURE);
    assign frame_done = done_q;
    assign row        = row_q;
    assign col        = col_q;
    assign pix_sum    = sum_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_conv_frame_writer.sv
// Self-checking bench for conv_frame_writer with a small frame (6x4 -> 4x4).
module tb_conv_frame_writer;

    localparam int unsigned W      = 6;
    localparam int unsigned H      = 4;
    localparam int unsigned OUT_W  = 4;
    localparam int unsigned ADDR_W = 5;
    localparam int          NPIX   = OUT_W * H;

    localparam int P_IDLE = 0;
    localparam int P_CAP  = 1;
    localparam int P_DONE = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        pxl_in;
    logic              valid_in;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              busy;
    logic              frame_done;
    logic [15:0]       row;
    logic [15:0]       col;
    logic [23:0]       pix_sum;
    logic [15:0]       drop_cnt;

    always #5 clk = ~clk;

    conv_frame_writer #(
        .W      (W),
        .H      (H),
        .OUT_W  (OUT_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pxl_in     (pxl_in),
        .valid_in   (valid_in),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .frame_done (frame_done),
        .row        (row),
        .col        (col),
        .pix_sum    (pix_sum),
        .drop_cnt   (drop_cnt)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: pixels written so far, frame image, sums.
    logic [7:0]  m_mem [NPIX];
    bit          m_known [NPIX];
    int          m_phase;
    int          m_n;
    logic [23:0] m_sum;
    int          m_drop;
    bit          m_fd;
    logic [7:0]  m_rd;
    bit          m_rd_known;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int erow;
        int ecol;
        if (m_n == NPIX) begin
            erow = H - 1;
            ecol = OUT_W - 1;
        end else begin
            erow = m_n / OUT_W;
            ecol = m_n % OUT_W;
        end
        check_eq("busy", 32'(busy), 32'(m_phase == P_CAP));
        check_eq("frame_done", 32'(frame_done), 32'(m_fd));
        check_eq("row", 32'(row), 32'(erow));
        check_eq("col", 32'(col), 32'(ecol));
        check_eq("pix_sum", 32'(pix_sum), 32'(m_sum));
        check_eq("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (m_rd_known) check_eq("rd_data", 32'(rd_data), 32'(m_rd));
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; valid_in = 1'b0; pxl_in = '0; rd_addr = '0;
        @(posedge clk);
        m_phase = P_IDLE; m_n = 0; m_sum = '0; m_drop = 0; m_fd = 0;
        m_rd = '0; m_rd_known = 1;
        #1;
        reset = 1'b0;
        check_all();
    endtask

    task automatic step(input bit st, input bit v, input logic [7:0] px, input int ra);
        start = st; valid_in = v; pxl_in = px; rd_addr = ADDR_W'(ra);
        @(posedge clk);
        m_rd = m_mem[ra];
        m_rd_known = m_known[ra];
        m_fd = 0;
        if (m_phase == P_CAP) begin
            if (v) begin
                m_mem[m_n] = px;
                m_known[m_n] = 1;
                m_sum = m_sum + 24'(px);
                m_n++;
                if (m_n == NPIX) begin
                    m_phase = P_DONE;
                    m_fd = 1;
                end
            end
        end else begin
            if (v && m_drop < 65535) m_drop++;
            if (st) begin
                m_phase = P_CAP;
                m_n = 0;
                m_sum = '0;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) m_known[i] = 0;
        do_reset();
        check_eq("reset_rd_data", 32'(rd_data), 32'h0);

        // Contiguous full frame with 1..16, plus row/col wrap points.
        step(1, 0, 8'd0, 0);
        for (int i = 1; i <= 16; i++) begin
            step(0, 1, 8'(i), 0);
            if (i == 5) begin
                check_eq("wrap5_row", 32'(row), 32'd1);
                check_eq("wrap5_col", 32'(col), 32'd1);
            end
            if (i == 8) begin
                check_eq("wrap8_row", 32'(row), 32'd2);
                check_eq("wrap8_col", 32'(col), 32'd0);
            end
        end
        check_eq("full_done", 32'(frame_done), 32'd1);
        check_eq("full_busy", 32'(busy), 32'd0);
        check_eq("full_sum", 32'(pix_sum), 32'd136);
        for (int a = 0; a < NPIX; a++) begin
            step(0, 0, 8'd0, a);
            check_eq("full_read", 32'(rd_data), 32'(a + 1));
        end

        // Gapped stream, valid every other cycle.
        step(1, 0, 8'd0, 0);
        for (int i = 1; i <= 16; i++) begin
            step(0, 1, 8'(i), 0);
            if (i < 16) step(0, 0, 8'd0, 0);
        end
        check_eq("gap_done", 32'(frame_done), 32'd1);
        check_eq("gap_sum", 32'(pix_sum), 32'd136);
        for (int a = 0; a < NPIX; a++) begin
            step(0, 0, 8'd0, a);
            check_eq("gap_read", 32'(rd_data), 32'(a + 1));
        end

        // Drops in IDLE and DONE.
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 1, 8'($urandom), 0);
        check_eq("drop_idle", 32'(drop_cnt), 32'd3);
        step(1, 0, 8'd0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 8'(200 + i), 0);
        for (int i = 0; i < 4; i++) step(0, 1, 8'($urandom), 0);
        check_eq("drop_total", 32'(drop_cnt), 32'd7);
        for (int a = 0; a < NPIX; a++) begin
            step(0, 0, 8'd0, a);
            check_eq("drop_read", 32'(rd_data), 32'(200 + a));
        end

        // Reset mid-frame, then a frame of constant 100.
        step(1, 0, 8'd0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 8'(i + 50), 0);
        do_reset();
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_row", 32'(row), 32'd0);
        check_eq("abort_col", 32'(col), 32'd0);
        check_eq("abort_sum", 32'(pix_sum), 32'd0);
        step(1, 0, 8'd0, 0);
        for (int i = 0; i < 16; i++) step(0, 1, 8'd100, 0);
        check_eq("c100_done", 32'(frame_done), 32'd1);
        check_eq("c100_sum", 32'(pix_sum), 32'd1600);

        // Read/write collision on address 3.
        step(1, 0, 8'd0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'(10 + i), 0);
        step(0, 1, 8'hAA, 3);
        check_eq("coll_old", 32'(rd_data), 32'd100);
        step(0, 0, 8'd0, 3);
        check_eq("coll_new", 32'(rd_data), 32'hAA);
        for (int i = 4; i < 16; i++) step(0, 1, 8'(i), 0);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            int r;
            bit st;
            bit v;
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                do_reset();
            end else begin
                st = (r < 8);
                v  = !st && ($urandom_range(0, 2) != 0);
                step(st, v, 8'($urandom), int'($urandom_range(0, NPIX - 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
